// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and the request legality check.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_MERGE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Reserved size, odd half address, or non-word-aligned word address.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      SIZE_WORD: return offs != 2'b00;
      SIZE_HALF: return offs[0];
      SIZE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational store merge: overlays right-justified store data onto the old word, little-endian.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_WORD: merged = wdata;
      SIZE_HALF: begin
        if (offs[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SIZE_BYTE: begin
        case (offs)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with WAIT_STATES latency and read-modify-write sub-word stores.
// Busy requests are ignored (req_ready low); the one-cycle response has no backpressure.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t             state, state_nxt;
  logic               wr_q;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         cnt;
  logic [31:0]        old_word;
  logic [31:0]        merged;
  logic [31:0]        rd_word;
  logic               mem_we;
  logic               accept;
  logic               bad_req;
  logic               sub_store;
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        mem [0:2**ADDR_W-1];

  // Address bits above the array wrap around and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept    = req_valid && req_ready;
  assign bad_req   = req_is_bad(req_size, req_addr[1:0]);
  assign sub_store = wr_q && (size_q != SIZE_WORD);
  assign idx       = addr_q[ADDR_W+1:2];
  assign rd_word   = mem[idx];
  assign mem_we    = (state == ST_ACCESS && wr_q && size_q == SIZE_WORD) || (state == ST_MERGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_req)               state_nxt = ST_RESP;
          else if (WAIT_STATES == 0) state_nxt = ST_ACCESS;
          else                       state_nxt = ST_WAIT;
        end
      end
      ST_WAIT:   if (cnt <= 4'd1) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = sub_store ? ST_MERGE : ST_RESP;
      ST_MERGE:  state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q      <= 1'b0;
      size_q    <= SIZE_WORD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      old_word  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          wr_q    <= req_wr;
          size_q  <= req_size;
          addr_q  <= req_addr[ADDR_W+1:0];
          wdata_q <= req_wdata;
          cnt     <= 4'(WAIT_STATES);
          if (bad_req) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        ST_ACCESS: begin
          old_word <= rd_word;
          if (!sub_store) begin
            rsp_rdata <= rd_word;
            rsp_err   <= 1'b0;
          end
        end
        ST_MERGE: begin
          rsp_rdata <= old_word;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mem_lane_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .size     (size_q),
    .offs     (addr_q[1:0]),
    .merged   (merged)
  );

  // Storage is intentionally not reset; writes are gated by the reset-cleared FSM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int ADDR_W = 8;
  localparam int WS     = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [0:255];

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01) return addr % 2 != 0;
    if (size == 2'b00) return addr % 4 != 0;
    return 1'b0;
  endfunction

  function automatic int m_lat(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    if (m_err(size, addr)) return 1;
    if (wr && size != 2'b00) return WS + 3;
    return WS + 2;
  endfunction

  // Returns expected rsp_rdata and commits the store into the model.
  function automatic logic [31:0] m_apply(input logic wr, input logic [1:0] size,
                                          input logic [31:0] addr, input logic [31:0] wdata);
    int w;
    logic [31:0] old;
    logic [31:0] nw;
    if (m_err(size, addr)) return 32'h0;
    w   = int'((addr / 4) % 256);
    old = model_mem[w];
    nw  = old;
    if (wr) begin
      if (size == 2'b00)      nw = wdata;
      else if (size == 2'b01) nw[16*int'((addr % 4) / 2) +: 16] = wdata[15:0];
      else                    nw[8*int'(addr % 4) +: 8] = wdata[7:0];
      model_mem[w] = nw;
    end
    return old;
  endfunction

  // Drives one request starting at a negedge, returns at a negedge one cycle after the response.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat, output logic ready_ok, output logic pulse_ok);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    ready_ok  = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    pulse_ok = !rsp_valid && req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, required 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_init;
    logic [31:0] rd; logic er, rok, pok; int lat; logic [31:0] wd;
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      void'(m_apply(1'b1, 2'b00, 32'(i * 4), wd));
      issue(1'b1, 2'b00, 32'(i * 4), wd, rd, er, lat, rok, pok);
      vectors++;
      if (er !== 1'b0 || lat != WS + 2 || rok !== 1'b1 || pok !== 1'b1) begin
        miscompares++;
        $display("FAIL init_store[%0d]: err=%b lat=%0d ready=%b pulse=%b, required 0/%0d/1/1", i, er, lat, rok, pok, WS + 2);
      end
    end
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd; logic er, rok, pok; int lat;
    void'(m_apply(1'b1, 2'b00, 32'h10, 32'hDEADBEEF));
    issue(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, lat, rok, pok);
    issue(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
      miscompares++;
      $display("FAIL word_load: rdata=%h err=%b lat=%0d, required deadbeef/0/3", rd, er, lat);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er, rok, pok; int lat;
    issue(1'b1, 2'b00, 32'h10, 32'h11223344, rd, er, lat, rok, pok);
    issue(1'b1, 2'b10, 32'h13, 32'h000000AA, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== 32'h11223344 || er !== 1'b0 || lat != 4) begin
      miscompares++;
      $display("FAIL byte_store_rsp: rdata=%h err=%b lat=%0d, required 11223344/0/4", rd, er, lat);
    end
    issue(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== 32'hAA223344) begin
      miscompares++;
      $display("FAIL byte_merge: rdata=%h, required aa223344", rd);
    end
    issue(1'b1, 2'b01, 32'h12, 32'h00005566, rd, er, lat, rok, pok);
    issue(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== 32'h55663344) begin
      miscompares++;
      $display("FAIL half_merge: rdata=%h, required 55663344", rd);
    end
    issue(1'b1, 2'b10, 32'h11, 32'h00000077, rd, er, lat, rok, pok);
    issue(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== 32'h55667744) begin
      miscompares++;
      $display("FAIL byte1_merge: rdata=%h, required 55667744", rd);
    end
    model_mem[4] = 32'h55667744;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er, rok, pok; int lat;
    logic [31:0] eaddr [3] = '{32'h0E, 32'h01, 32'h08};
    logic [1:0]  esize [3] = '{2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, esize[i], eaddr[i], 32'hFFFF_FFFF, rd, er, lat, rok, pok);
      vectors++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || pok !== 1'b1) begin
        miscompares++;
        $display("FAIL err_case[%0d]: err=%b rdata=%h lat=%0d pulse=%b, required 1/0/1/1", i, er, rd, lat, pok);
      end
      issue(1'b0, 2'b00, eaddr[i] & 32'hFFFF_FFFC, 32'h0, rd, er, lat, rok, pok);
      vectors++;
      if (rd !== model_mem[(eaddr[i] / 4) % 256] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL err_nowrite[%0d]: rdata=%h, required %h", i, rd, model_mem[(eaddr[i] / 4) % 256]);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; logic er, rok, pok; int lat;
    logic [31:0] keep;
    keep = model_mem[8];
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = ~keep;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: valid=%b rdata=%h, required 0/0", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready: req_ready=%b, required 1", req_ready);
    end
    @(negedge clk);
    issue(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== keep) begin
      miscompares++;
      $display("FAIL abort_nowrite: rdata=%h, required %h", rd, keep);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er, rok, pok; int lat; logic [31:0] wd;
    wd = $urandom;
    void'(m_apply(1'b1, 2'b00, 32'h400, wd));
    issue(1'b1, 2'b00, 32'h400, wd, rd, er, lat, rok, pok);
    issue(1'b0, 2'b00, 32'h000, 32'h0, rd, er, lat, rok, pok);
    vectors++;
    if (rd !== wd) begin
      miscompares++;
      $display("FAIL wrap: rdata=%h, required %h", rd, wd);
    end
  endtask

  task automatic test_busy_hold;
    int acc = 0, rsp = 0, bad_data = 0;
    req_wr = 1'b0; req_size = 2'b00; req_addr = 32'h30;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) acc++;
      if (rsp_valid) begin
        rsp++;
        if (rsp_rdata !== model_mem[12] || rsp_err !== 1'b0) bad_data++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if (acc != 40 / (WS + 3) || rsp != 40 / (WS + 3) || bad_data != 0) begin
      miscompares++;
      $display("FAIL busy_hold: accepts=%0d responses=%0d bad=%0d, required %0d/%0d/0", acc, rsp, bad_data, 40 / (WS + 3), 40 / (WS + 3));
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] rd, ex, addr, wd; logic er, rok, pok, wr; logic [1:0] sz; int lat;
    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      ex   = m_apply(wr, sz, addr, wd);
      issue(wr, sz, addr, wd, rd, er, lat, rok, pok);
      vectors++;
      if (rd !== ex || er !== m_err(sz, addr) || lat != m_lat(wr, sz, addr) || rok !== 1'b1 || pok !== 1'b1) begin
        miscompares++;
        $display("FAIL random[%0d] wr=%b sz=%0d addr=%h: rdata=%h err=%b lat=%0d rdy=%b pulse=%b, required %h/%b/%0d/1/1",
                 i, wr, sz, addr, rd, er, lat, rok, pok, ex, m_err(sz, addr), m_lat(wr, sz, addr));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er, rok, pok; int lat; logic [31:0] wd;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      void'(m_apply(1'b1, 2'b00, 32'(i * 4 + 64), wd));
      issue(1'b1, 2'b00, 32'(i * 4 + 64), wd, rd, er, lat, rok, pok);
      issue(1'b0, 2'b00, 32'(i * 4 + 64), 32'h0, rd, er, lat, rok, pok);
      vectors++;
      if (rd !== wd || rok !== 1'b1 || lat != WS + 2) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: rdata=%h ready=%b lat=%0d, required %h/1/%0d", i, rd, rok, lat, wd, WS + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_word_store_load();
    test_subword();
    test_errors();
    test_reset_mid_wait();
    test_wrap();
    test_busy_hold();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
